// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory req/gnt/rvalid port, decode valid/ready port and redirect input.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, response FIFO to decode,
// and redirect handling that discards responses still outstanding at redirect time.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic [SW-1:0] credit_c;
  logic          req_c;
  logic          valid_c;
  logic          grant_c;
  logic          pop_c;
  logic          push_c;
  logic [31:0]   redir_pc_c;

  // Credit counts buffered plus outstanding (including to-be-dropped) so the FIFO cannot overflow.
  always_comb begin
    credit_c   = SW'(count) + SW'(inflight);
    req_c      = rst_n && !bus.redirect_valid && (credit_c < SW'(FIFO_DEPTH));
    valid_c    = (count != '0) && !bus.redirect_valid;
    grant_c    = req_c && bus.imem_gnt;
    pop_c      = valid_c && bus.if_ready;
    push_c     = bus.imem_rvalid && (drop == '0) && !bus.redirect_valid;
    redir_pc_c = bus.redirect_pc & ~32'h3;
  end

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = valid_c;
  assign bus.if_instr  = instr_mem[rd_ptr];
  assign bus.if_pc     = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      // No request is issued under redirect, so only a response can retire this cycle.
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pc       <= redir_pc_c;
      resp_pc  <= redir_pc_c;
      drop     <= inflight - CW'(bus.imem_rvalid);
      inflight <= inflight - CW'(bus.imem_rvalid);
    end else begin
      if (grant_c) begin
        pc <= pc + 32'd4;
      end
      inflight <= inflight + CW'(grant_c) - CW'(bus.imem_rvalid);
      if (bus.imem_rvalid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (push_c) begin
        instr_mem[wr_ptr] <= bus.imem_rdata;
        pc_mem[wr_ptr]    <= resp_pc;
        wr_ptr            <= wr_ptr + AW'(1);
        resp_pc           <= resp_pc + 32'd4;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_c) - CW'(pop_c);
    end
  end

  // Protocol sanity: memory never answers without an outstanding request; buffer never overfills.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.imem_rvalid && (inflight == '0)));
      assert (count <= CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the fetch stream.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  // Model: outstanding memory requests tagged with the redirect epoch they were issued in,
  // and the PCs of instructions buffered for decode.
  pend_t       pending[$];
  logic [31:0] buffered[$];
  logic [31:0] fetch_pc;
  int          epoch;
  int          cyc;

  int vectors;
  int errors;

  int          gnt_pct   = 100;
  int          rdy_pct   = 100;
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          redir_pct = 0;
  bit          force_redir;
  logic [31:0] force_target;
  bit          redir_when_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
    check({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
    check({tag, "_if_instr"}, bus.if_instr, 32'd0);
    check({tag, "_if_pc"}, bus.if_pc, 32'd0);
  endtask

  task automatic step();
    bit          rv, gn, rd, redir, exp_req, exp_valid;
    logic [31:0] tgt;
    pend_t       e;
    @(negedge clk);
    rv    = (pending.size() != 0) && (pending[0].due <= cyc);
    gn    = $urandom_range(99) < gnt_pct;
    rd    = $urandom_range(99) < rdy_pct;
    redir = $urandom_range(99) < redir_pct;
    tgt   = $urandom;
    if (force_redir) begin
      redir       = 1'b1;
      tgt         = force_target;
      force_redir = 1'b0;
    end
    if (redir_when_busy && rv && (buffered.size() != 0)) begin
      redir           = 1'b1;
      rd              = 1'b1;
      redir_when_busy = 1'b0;
    end
    bus.imem_gnt       = gn;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? (pending[0].addr ^ KEY) : $urandom;
    bus.if_ready       = rd;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    #1;
    exp_req   = !redir && (buffered.size() + pending.size() < DEPTH);
    exp_valid = (buffered.size() != 0) && !redir;
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check("imem_addr", bus.imem_addr, fetch_pc);
    check("if_valid", 32'(bus.if_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("if_pc", bus.if_pc, buffered[0]);
      check("if_instr", bus.if_instr, buffered[0] ^ KEY);
    end
    if (rv) e = pending.pop_front();
    if (redir) begin
      buffered.delete();
      epoch++;
      fetch_pc = {tgt[31:2], 2'b00};
    end else begin
      if (exp_valid && rd) void'(buffered.pop_front());
      if (rv && (e.epoch == epoch)) buffered.push_back(e.addr);
      if (exp_req && gn) begin
        pending.push_back('{addr: fetch_pc, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic wait_two_inflight(input string tag);
    int n = 0;
    while (pending.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(pending.size()), 32'd2);
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    epoch    = 0;
    cyc      = 0;
    fetch_pc = RESET_PC;
    rst_n    = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Streaming with single-cycle memory and decode always ready.
    repeat (30) step();

    // Decode stalls: buffer fills to two, then drains in order.
    rdy_pct = 0;
    repeat (10) step();
    rdy_pct = 100;
    repeat (10) step();

    // Grant withheld: address must hold.
    gnt_pct = 0;
    repeat (3) step();
    gnt_pct = 100;
    repeat (5) step();

    // Redirect with two stale responses outstanding on a slow memory.
    lat_min = 3;
    lat_max = 3;
    wait_two_inflight("two_inflight_before_redirect");
    force_redir  = 1'b1;
    force_target = 32'h0000_0103;
    repeat (20) step();

    // Redirect colliding with a pop and a response in the same cycle.
    lat_min = 1;
    lat_max = 1;
    redir_when_busy = 1'b1;
    for (int i = 0; i < 50 && redir_when_busy; i++) step();
    check("busy_redirect_hit", 32'(redir_when_busy), 32'd0);
    repeat (10) step();

    // Reset in the middle of traffic.
    lat_min = 3;
    lat_max = 3;
    wait_two_inflight("two_inflight_before_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("midreset");
    pending.delete();
    buffered.delete();
    fetch_pc = RESET_PC;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();

    // Random traffic: sporadic grants, stalls, latencies and redirects.
    gnt_pct   = 70;
    rdy_pct   = 70;
    lat_min   = 1;
    lat_max   = 4;
    redir_pct = 5;
    repeat (2000) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
